// File: rtl/column_pkg.sv
// Shared parameters, pixel state encoding and word/config field positions
// for the 16-pixel readout column.
package column_pkg;

    localparam int NPIX   = 16;
    localparam int TS_W   = 9;
    localparam int TOT_W  = 12;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int CFG_W  = 4 * NPIX;
    localparam int COL_W  = 1 + ADDR_W + TS_W + TOT_W;

    // col_data layout: {valid, addr, toa, tot}
    localparam int COL_VALID_BIT = COL_W - 1;
    localparam int COL_ADDR_LSB  = TS_W + TOT_W;
    localparam int COL_TOA_LSB   = TOT_W;
    localparam int COL_TOT_LSB   = 0;

    // Bit positions inside each pixel's configuration nibble
    localparam int CFG_EN_BIT   = 3;
    localparam int CFG_TP_BIT   = 2;
    localparam int CFG_TRIM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } pix_state_e;

    function automatic logic [TOT_W-1:0] sat_inc(input logic [TOT_W-1:0] v);
        return (v == {TOT_W{1'b1}}) ? v : v + TOT_W'(1);
    endfunction

endpackage

// File: rtl/super_pixel_cell.sv
// Single pixel front-end: ToA/ToT capture in mode 0, shutter-gated hit
// counting in mode 1, released to IDLE when the column reads it out.
module super_pixel_cell
    import column_pkg::*;
(
    input  logic             clk_40MHz,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic             i_eh,
    input  logic             i_shutter,
    input  logic             i_shutter_fall,
    input  logic [TS_W-1:0]  i_ts,
    input  logic             i_rd,
    output logic             o_ready,
    output logic [TS_W-1:0]  o_toa,
    output logic [TOT_W-1:0] o_tot
);

    pix_state_e       r_state;
    logic [TS_W-1:0]  r_toa;
    logic [TOT_W-1:0] r_tot;
    logic             r_eh_d;
    logic             w_rise;

    assign w_rise  = i_eh & ~r_eh_d;
    assign o_ready = (r_state == READY);
    assign o_toa   = r_toa;
    assign o_tot   = r_tot;

    // Pixel state machine with ToA/ToT/count registers and hit edge history
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_toa   <= '0;
            r_tot   <= '0;
            r_eh_d  <= 1'b0;
        end else if (i_clear) begin
            r_state <= IDLE;
            r_toa   <= '0;
            r_tot   <= '0;
            r_eh_d  <= 1'b0;
        end else begin
            r_eh_d <= i_eh;
            if (i_rd) begin
                // Readout wins over any hit arriving in the same cycle
                r_state <= IDLE;
                r_toa   <= '0;
                r_tot   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!i_mode) begin
                            if (w_rise) begin
                                r_toa   <= i_ts;
                                r_tot   <= TOT_W'(1);
                                r_state <= BUSY;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_toa <= '0;
                            if (i_shutter && w_rise) begin
                                r_tot <= sat_inc(r_tot);
                            end else begin
                                r_tot <= r_tot;
                            end
                            if (i_shutter_fall && (r_tot != '0)) begin
                                r_state <= READY;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    BUSY: begin
                        if (i_eh) begin
                            r_tot <= sat_inc(r_tot);
                        end else begin
                            r_state <= READY;
                        end
                    end
                    READY: begin
                        r_state <= READY;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_toa   <= '0;
                        r_tot   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/column_super_pixel.sv
// Readout column: config shift register, 16 pixel cells, priority arbiter
// and handshaked readout register. Optional hit_or_column via HIT_OR_COLUMN_EN.
module column_super_pixel
    import column_pkg::*;
(
    input  logic             clk_40MHz,
    input  logic             rst_n,
    input  logic             rst_n_pixel,
    input  logic [NPIX-1:0]  hit,
    input  logic             Dpulse,
    input  logic [TS_W-1:0]  TimeStamp,
    input  logic             mode,
    input  logic             shutter,
    input  logic [5:0]       config_info,
    input  logic             shake_hands_col,
    output logic [CFG_W-1:0] config_DAC,
    output logic [COL_W-1:0] col_data
`ifdef HIT_OR_COLUMN_EN
    ,
    output logic             hit_or_column
`endif
);

    logic [CFG_W-1:0]  r_config;
    logic [COL_W-1:0]  r_col_data;
    logic              r_mode_d;
    logic              r_shutter_d;

    logic [NPIX-1:0]   w_en;
    logic [NPIX-1:0]   w_tp;
    logic [NPIX-1:0]   w_eh;
    logic [NPIX-1:0]   w_ready;
    logic [NPIX-1:0]   w_rd;
    logic [TS_W-1:0]   w_toa [NPIX];
    logic [TOT_W-1:0]  w_tot [NPIX];
    logic              w_clear;
    logic              w_load;
    logic              w_shutter_fall;
    logic              w_sel_valid;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [TS_W-1:0]   w_sel_toa;
    logic [TOT_W-1:0]  w_sel_tot;

    assign config_DAC     = r_config;
    assign col_data       = r_col_data;
    assign w_clear        = ~rst_n_pixel | (mode != r_mode_d);
    assign w_load         = ~r_col_data[COL_VALID_BIT] | shake_hands_col;
    assign w_shutter_fall = r_shutter_d & ~shutter;
    assign w_eh           = w_en & (hit | ({NPIX{Dpulse}} & w_tp));
    assign w_sel_toa      = w_toa[w_sel_addr];
    assign w_sel_tot      = w_tot[w_sel_addr];

    // Config shift register: only the 2'b11 command shifts a nibble in
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_config <= '0;
        end else if (config_info[5:4] == 2'b11) begin
            r_config <= {config_info[3:0], r_config[CFG_W-1:4]};
        end else begin
            r_config <= r_config;
        end
    end

    // Mode and shutter history for change/falling-edge detection
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_d    <= 1'b0;
            r_shutter_d <= 1'b0;
        end else begin
            r_mode_d    <= mode;
            r_shutter_d <= shutter;
        end
    end

    // Lowest-index READY pixel wins the readout slot
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = '0;
        for (int i = NPIX - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_valid = 1'b1;
                w_sel_addr  = ADDR_W'(i);
            end else begin
                w_sel_valid = w_sel_valid;
            end
        end
    end

    // Readout register; invalid slots keep the previous payload fields
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_col_data <= '0;
        end else if (w_clear) begin
            r_col_data <= '0;
        end else if (w_load) begin
            if (w_sel_valid) begin
                r_col_data <= {1'b1, w_sel_addr, w_sel_toa, w_sel_tot};
            end else begin
                r_col_data[COL_VALID_BIT] <= 1'b0;
            end
        end else begin
            r_col_data <= r_col_data;
        end
    end

    for (genvar g = 0; g < NPIX; g++) begin : g_pix
        assign w_en[g] = r_config[4*g + CFG_EN_BIT];
        assign w_tp[g] = r_config[4*g + CFG_TP_BIT];
        assign w_rd[g] = w_load & w_sel_valid & (w_sel_addr == ADDR_W'(g)) & ~w_clear;

        super_pixel_cell u_cell (
            .clk_40MHz      (clk_40MHz),
            .rst_n          (rst_n),
            .i_clear        (w_clear),
            .i_mode         (mode),
            .i_eh           (w_eh[g]),
            .i_shutter      (shutter),
            .i_shutter_fall (w_shutter_fall),
            .i_ts           (TimeStamp),
            .i_rd           (w_rd[g]),
            .o_ready        (w_ready[g]),
            .o_toa          (w_toa[g]),
            .o_tot          (w_tot[g])
        );
    end

`ifdef HIT_OR_COLUMN_EN
    logic r_hit_or;

    assign hit_or_column = r_hit_or;

    // Registered column-wide OR of effective hits
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_or <= 1'b0;
        end else begin
            r_hit_or <= |w_eh;
        end
    end
`endif

endmodule

// File: tb/tb_column_super_pixel.sv
// Directed self-checking bench for column_super_pixel.
module tb_column_super_pixel;

    logic        clk_40MHz;
    logic        rst_n;
    logic        rst_n_pixel;
    logic [15:0] hit;
    logic        Dpulse;
    logic [8:0]  TimeStamp;
    logic        mode;
    logic        shutter;
    logic [5:0]  config_info;
    logic        shake_hands_col;
    logic [63:0] config_DAC;
    logic [25:0] col_data;
`ifdef HIT_OR_COLUMN_EN
    logic        hit_or_column;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    column_super_pixel dut (
        .clk_40MHz       (clk_40MHz),
        .rst_n           (rst_n),
        .rst_n_pixel     (rst_n_pixel),
        .hit             (hit),
        .Dpulse          (Dpulse),
        .TimeStamp       (TimeStamp),
        .mode            (mode),
        .shutter         (shutter),
        .config_info     (config_info),
        .shake_hands_col (shake_hands_col),
        .config_DAC      (config_DAC),
        .col_data        (col_data)
`ifdef HIT_OR_COLUMN_EN
        ,
        .hit_or_column   (hit_or_column)
`endif
    );

    initial clk_40MHz = 1'b0;
    always #10 clk_40MHz = ~clk_40MHz;

    task automatic step();
        @(posedge clk_40MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input logic [3:0] a, input logic [8:0] t, input logic [11:0] c);
        return {38'd0, 1'b1, a, t, c};
    endfunction

    task automatic cfg_write(input logic [63:0] v);
        for (int k = 0; k < 16; k++) begin
            config_info = {2'b11, v[4*k +: 4]};
            step();
        end
        config_info = 6'b000000;
    endtask

    initial begin
        rst_n = 1'b0; rst_n_pixel = 1'b1; hit = 16'd0; Dpulse = 1'b0;
        TimeStamp = 9'd0; mode = 1'b0; shutter = 1'b0; config_info = 6'd0;
        shake_hands_col = 1'b1;
        step(); step();
        check("reset_config", {0'b0, config_DAC}, 64'd0);
        check("reset_col", {38'd0, col_data}, 64'd0);
        rst_n = 1'b1;
        step();

        // Configuration shift and non-shift command
        config_info = 6'b111100;
        repeat (16) step();
        check("cfg_shift", config_DAC, 64'hCCCC_CCCC_CCCC_CCCC);
        config_info = 6'b011111;
        repeat (4) step();
        check("cfg_hold", config_DAC, 64'hCCCC_CCCC_CCCC_CCCC);
        config_info = 6'b000000;
        cfg_write(64'h0123_4567_89AB_CDEF);
        check("cfg_order", config_DAC, 64'h0123_4567_89AB_CDEF);
        cfg_write(64'hCCCC_CCCC_CCCC_CCCC);

        // Mode 0 single hit on pixel 5, 2 cycles, starting at TimeStamp 37
        hit[5] = 1'b1; TimeStamp = 9'd37;
        step();
`ifdef HIT_OR_COLUMN_EN
        check("hit_or", {63'd0, hit_or_column}, 64'd1);
`endif
        TimeStamp = 9'd38;
        step();
        hit[5] = 1'b0; TimeStamp = 9'd39;
        step();
        check("single_early", {63'd0, col_data[25]}, 64'd0);
        step();
        check("single_word", {38'd0, col_data}, word(4'd5, 9'd37, 12'd2));
        step();
        check("single_after", {63'd0, col_data[25]}, 64'd0);

        // Arbitration between pixels 3 and 9 with handshake held low
        hit[3] = 1'b1; hit[9] = 1'b1; TimeStamp = 9'd100;
        step();
        TimeStamp = 9'd101;
        step();
        hit[3] = 1'b0; hit[9] = 1'b0; shake_hands_col = 1'b0;
        step();
        step();
        check("arb_first", {38'd0, col_data}, word(4'd3, 9'd100, 12'd2));
        for (int k = 0; k < 3; k++) begin
            step();
            check("arb_hold", {38'd0, col_data}, word(4'd3, 9'd100, 12'd2));
        end
        shake_hands_col = 1'b1;
        step();
        check("arb_second", {38'd0, col_data}, word(4'd9, 9'd100, 12'd2));
        step();
        check("arb_done", {63'd0, col_data[25]}, 64'd0);

        // Test pulse on all pixels for 3 cycles, 16-word stream
        Dpulse = 1'b1; TimeStamp = 9'd200;
        repeat (3) step();
        Dpulse = 1'b0; TimeStamp = 9'd210;
        step();
        check("tp_ready_no_word", {63'd0, col_data[25]}, 64'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            check("tp_stream", {38'd0, col_data}, word(4'(k), 9'd200, 12'd3));
        end
        step();
        check("tp_done", {63'd0, col_data[25]}, 64'd0);

        // Masked pixel 2 and ToT saturation on pixel 4
        cfg_write(64'hCCCC_CCCC_CCCC_C4CC);
        check("cfg_mask", config_DAC, 64'hCCCC_CCCC_CCCC_C4CC);
        hit[2] = 1'b1; hit[4] = 1'b1; TimeStamp = 9'd300;
        step();
        TimeStamp = 9'd301;
        repeat (10) step();
        check("sat_busy_no_word", {63'd0, col_data[25]}, 64'd0);
        repeat (4989) step();
        hit[2] = 1'b0; hit[4] = 1'b0;
        step();
        check("sat_ready_no_word", {63'd0, col_data[25]}, 64'd0);
        step();
        check("sat_word", {38'd0, col_data}, word(4'd4, 9'd300, 12'd4095));
        step();
        check("mask_no_word", {63'd0, col_data[25]}, 64'd0);

        // Mode 1 event counting, 7 pulses on pixel 1
        mode = 1'b1; TimeStamp = 9'd55;
        step(); step();
        shutter = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            hit[1] = 1'b1;
            step();
            hit[1] = 1'b0;
            step();
        end
        check("cnt_window_no_word", {63'd0, col_data[25]}, 64'd0);
        shutter = 1'b0;
        step();
        check("cnt_ready_no_word", {63'd0, col_data[25]}, 64'd0);
        step();
        check("cnt_word", {38'd0, col_data}, word(4'd1, 9'd0, 12'd7));
        step();
        check("cnt_done", {63'd0, col_data[25]}, 64'd0);

        // Mode 1 window aborted by pixel reset: no word
        shutter = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            hit[1] = 1'b1;
            step();
            hit[1] = 1'b0;
            step();
        end
        rst_n_pixel = 1'b0;
        step();
        rst_n_pixel = 1'b1; shutter = 1'b0;
        step();
        step();
        check("cnt_abort_1", {63'd0, col_data[25]}, 64'd0);
        step();
        check("cnt_abort_2", {63'd0, col_data[25]}, 64'd0);
        check("cfg_kept", config_DAC, 64'hCCCC_CCCC_CCCC_C4CC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/column_super_pixel.md
Name: column_super_pixel

Overview:
- One readout column of 16 pixel front-ends, all clocked by clk_40MHz.
- Each pixel captures hit arrival time (ToA, from an external 9-bit timestamp) and time-over-threshold (ToT) in mode 0, or counts hits inside a shutter window in mode 1.
- Finished pixels are read out one 26-bit word at a time through a priority arbiter, with a column-level handshake.
- The block also holds the 64-bit per-pixel configuration register for the column.

Parameters:
- NPIX, 16, pixels per column; address width is clog2(NPIX).
- TS_W, 9, timestamp/ToA width.
- TOT_W, 12, ToT/count width.

Ports:
- clk_40MHz  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset of the whole block, including config.
- rst_n_pixel  in  1  synchronous active-low clear of pixel state and readout register; config is kept.
- hit  in  16  discriminator outputs, synchronous to clk; bit i = pixel i.
- Dpulse  in  1  digital test pulse.
- TimeStamp  in  9  binary timestamp.
- mode  in  1  0 = ToA/ToT, 1 = event counting.
- shutter  in  1  counting window, mode 1 only.
- config_info  in  6  configuration command/data.
- shake_hands_col  in  1  periphery ready to accept col_data.
- config_DAC  out  64  per-pixel config; nibble i = bits [4i+3:4i].
- col_data  out  26  {valid[25], addr[24:21], toa[20:12], tot[11:0]}.

Behaviour:
- Reset (rst_n=0): config_DAC=0, col_data=0, all pixels IDLE, all pixel registers 0.
- Configuration:
  - Every cycle with config_info[5:4]==2'b11: config_DAC <= {config_info[3:0], config_DAC[63:4]}.
  - After 16 shifts, the first nibble written sits in pixel 0; other command codes leave config_DAC unchanged.
  - Shifting is independent of rst_n_pixel.
- Nibble bits: bit3 = pixel enable, bit2 = test-pulse enable, bits1:0 = DAC trim (output only).
- Effective hit: eh[i] = en[i] & (hit[i] | (Dpulse & tp_en[i])).
  - eh is registered once (eh_d) for edge detection.
- Pixel FSM, mode 0 (IDLE -> BUSY -> READY):
  - IDLE, rising edge of eh: toa <= TimeStamp, tot <= 1, go BUSY.
  - BUSY, eh=1: tot increments, saturating at 4095.
  - BUSY, eh=0: go READY.
  - READY: new hits are ignored; the pixel stays READY until read out.
- Pixel FSM, mode 1:
  - IDLE, shutter=1: each eh rising edge increments the count (saturating at 4095); toa is held 0.
  - Shutter falling edge: pixels with count>0 go READY; pixels with count 0 stay IDLE.
- Readout register:
  - Loads when col_data[25]==0 or shake_hands_col==1.
  - Source is the lowest-index READY pixel: word = {1, addr, toa, tot}. That pixel returns to IDLE with cleared registers at the same edge.
  - If no pixel is READY, col_data[25] <= 0; the other fields hold their last value.
- Latency: 2-cycle hit in mode 0 -> valid word 3 cycles after the rising-edge sample, with tot=2. With shake_hands_col held 1, back-to-back words stream one per cycle.
- Simultaneous events:
  - Several READY pixels: served in index order.
  - Hit on a pixel in the same cycle it is read out: ignored.
- rst_n_pixel=0, or any cycle in which mode differs from its registered value:
  - All pixels go IDLE and eh_d clears.
  - col_data[25] clears at the next edge.
- Inputs are not resynchronised; external logic drives them synchronous to clk_40MHz.

Optional Feature:
- Macro HIT_OR_COLUMN_EN.
- Defined: adds output port hit_or_column (1 bit), registered OR of eh[15:0]; one-cycle latency; reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package column_pkg: NPIX, TS_W, TOT_W, pixel state enum (IDLE/BUSY/READY), col_data field offsets, config nibble bit positions.
- One sub-module, super_pixel_cell (single-pixel FSM plus ToA/ToT/count registers), instantiated 16 times.
- Arbiter, config shift register and readout register stay in the top.

Test Plan:
- Config: 16 cycles with config_info=6'b111100 -> config_DAC=64'hCCCC_CCCC_CCCC_CCCC; with config_info=6'b011111 -> config_DAC unchanged.
- Mode 0, single hit:
  - Stimulus: pixel 5 enabled; hit[5] high 2 cycles starting when TimeStamp=37; shake_hands_col=1.
  - Required: one word, col_data = {1, 4'd5, 9'd37, 12'd2}, valid 3 cycles after the rising-edge sample, then valid=0.
- Arbitration: hits on pixels 3 and 9 ending in the same cycle, shake_hands_col=0 for 4 cycles then 1 -> pixel 3's word holds while shake is low; pixel 9's word follows one cycle after shake rises.
- Test pulse: all nibbles 4'hC, rst_n_pixel released, Dpulse high 3 cycles -> 16 words, addr 0..15 in order, tot=3 each.
- Masking and saturation:
  - Pixel 2 with bit3=0, hit held -> no word for pixel 2.
  - Pixel 4 with hit held for 5000 cycles -> tot=4095.
- Mode 1: shutter high, 7 hit pulses on pixel 1, shutter falls -> word {1, 4'd1, 9'd0, 12'd7}. Pulling rst_n_pixel low instead of dropping the shutter -> no word.
